multiplier_slave: RTL and testbench



---
 rtl/multiplier_slave.sv | 184 ++++++++++++++++++
 tb/tb_multiplier_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_slave.sv
// Bus-slave radix-2 shift-add unsigned multiplier with a level completion interrupt.
// Optional MUL_EARLY_EXIT_EN: stop EXEC once all unconsumed multiplier bits are zero.
module multiplier_slave #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [7:0]        S_address,
  input  logic [DATA_W-1:0] S_din,
  output logic [DATA_W-1:0] S_dout,
  output logic              m_interrupt
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  localparam logic [7:0] AddrMcand  = 8'h00;
  localparam logic [7:0] AddrMplier = 8'h01;
  localparam logic [7:0] AddrStart  = 8'h02;
  localparam logic [7:0] AddrClear  = 8'h03;
  localparam logic [7:0] AddrStatus = 8'h04;
  localparam logic [7:0] AddrResL   = 8'h05;
  localparam logic [7:0] AddrResH   = 8'h06;
  localparam logic [7:0] AddrIntrEn = 8'h07;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] work_a_q, work_a_d;
  logic [DATA_W-1:0]   work_b_q, work_b_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                intr_en_q, intr_en_d;
  logic                irq_q, irq_d;

  logic                wr_en;
  logic                start_wr;
  logic                clear_wr;
  logic                last_bit;
  logic [2*DATA_W-1:0] acc_sum;

  assign wr_en    = S_sel & S_wr;
  assign start_wr = wr_en && (S_address == AddrStart) && S_din[0];
  assign clear_wr = wr_en && (S_address == AddrClear) && S_din[0];
  assign acc_sum  = acc_q + (work_b_q[0] ? work_a_q : '0);

`ifdef MUL_EARLY_EXIT_EN
  // Remaining multiplier bits after the one consumed this cycle are all zero.
  assign last_bit = (cnt_q == CntLast) || (work_b_q[DATA_W-1:1] == '0);
`else
  assign last_bit = (cnt_q == CntLast);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; OPCLEAR takes priority over completion and start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (clear_wr) state_d = StIdle; else if (start_wr) state_d = StExec;
      StExec: if (clear_wr) state_d = StIdle; else if (last_bit) state_d = StDone;
      StDone: if (clear_wr) state_d = StIdle; else if (start_wr) state_d = StExec;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    work_a_d  = work_a_q;
    work_b_d  = work_b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    busy_d    = busy_q;
    intr_en_d = intr_en_q;

    if (wr_en) begin
      case (S_address)
        AddrMcand:  mcand_d   = S_din;
        AddrMplier: mplier_d  = S_din;
        AddrIntrEn: intr_en_d = S_din[0];
        default: ;
      endcase
    end

    if (state_q == StExec) begin
      acc_d    = acc_sum;
      work_a_d = work_a_q << 1;
      work_b_d = work_b_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (last_bit) begin
        result_d = acc_sum;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
    end else if (start_wr) begin
      work_a_d = {{DATA_W{1'b0}}, mcand_q};
      work_b_d = mplier_q;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end

    if (clear_wr) begin
      mcand_d  = '0;
      mplier_d = '0;
      work_a_d = '0;
      work_b_d = '0;
      acc_d    = '0;
      result_d = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
      busy_d   = 1'b0;
    end

    // Registered from next-state values so it rises on the same edge as done
    irq_d = done_d & intr_en_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      work_a_q  <= '0;
      work_b_q  <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      intr_en_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      work_a_q  <= work_a_d;
      work_b_q  <= work_b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      intr_en_q <= intr_en_d;
      irq_q     <= irq_d;
    end
  end

  // Outputs: combinational read mux and registered interrupt
  always_comb begin
    S_dout      = '0;
    m_interrupt = irq_q;
    if (S_sel && !S_wr) begin
      case (S_address)
        AddrMcand:  S_dout = mcand_q;
        AddrMplier: S_dout = mplier_q;
        AddrStatus: S_dout = {{(DATA_W-2){1'b0}}, busy_q, done_q};
        AddrResL:   S_dout = result_q[DATA_W-1:0];
        AddrResH:   S_dout = result_q[2*DATA_W-1:DATA_W];
        AddrIntrEn: S_dout = {{(DATA_W-1){1'b0}}, intr_en_q};
        default:    S_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_slave.sv
// Directed self-checking bench for multiplier_slave (default DATA_W=32).
module tb_multiplier_slave;

  logic        clk;
  logic        reset_n;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic [31:0] S_dout;
  logic        m_interrupt;

  int checks;
  int failures;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LatZero = 1;
  localparam int LatFive = 3;
`else
  localparam int LatZero = 32;
  localparam int LatFive = 32;
`endif

  multiplier_slave #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .S_sel      (S_sel),
    .S_wr       (S_wr),
    .S_address  (S_address),
    .S_din      (S_din),
    .S_dout     (S_dout),
    .m_interrupt(m_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
    @(posedge clk);
    #1;
    S_sel = 1'b0; S_wr = 1'b0; S_din = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b0; S_address = a;
    #1;
    d = S_dout;
    S_sel = 1'b0;
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
    cyc(3);
    for (int a = 0; a < 8; a++) begin
      rd(8'(a), v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_reg%0d: got %h want 0", a, v); end
    end
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", m_interrupt); end
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic();
    logic [31:0] v;
    wr(8'h07, 32'h1); wr(8'h00, 32'd5); wr(8'h01, 32'd4);
    rd(8'h01, v);
    checks++; if (v !== 32'd4) begin failures++; $display("FAIL basic_mplier_rb: got %h want 4", v); end
    wr(8'h02, 32'h1);
    rd(8'h04, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL basic_busy: got %h want 2", v); end
    cyc(31);
    rd(8'h04, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL basic_busy31: got %h want 2", v); end
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL basic_irq31: got %b want 0", m_interrupt); end
    cyc(1);
    rd(8'h04, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL basic_done32: got %h want 1", v); end
    checks++; if (m_interrupt !== 1'b1) begin failures++; $display("FAIL basic_irq: got %b want 1", m_interrupt); end
    rd(8'h05, v);
    checks++; if (v !== 32'd20) begin failures++; $display("FAIL basic_resl: got %h want 14", v); end
    rd(8'h06, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL basic_resh: got %h want 0", v); end
    S_address = 8'h05; #1;
    checks++; if (S_dout !== 32'd0) begin failures++; $display("FAIL basic_nosel: got %h want 0", S_dout); end
    wr(8'h03, 32'h1);
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL basic_clr_irq: got %b want 0", m_interrupt); end
    rd(8'h05, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL basic_clr_resl: got %h want 0", v); end
    rd(8'h07, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL basic_intren_kept: got %h want 1", v); end
  endtask

  task automatic test_max();
    logic [31:0] v;
    wr(8'h00, 32'hFFFF_FFFF); wr(8'h01, 32'hFFFF_FFFF); wr(8'h02, 32'h1);
    cyc(32);
    rd(8'h06, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin failures++; $display("FAIL max_resh: got %h want fffffffe", v); end
    rd(8'h05, v);
    checks++; if (v !== 32'h0000_0001) begin failures++; $display("FAIL max_resl: got %h want 1", v); end
    wr(8'h03, 32'h1);
  endtask

  task automatic test_intr_late();
    logic [31:0] v;
    wr(8'h07, 32'h0); wr(8'h00, 32'd20); wr(8'h01, 32'd3); wr(8'h02, 32'h1);
    cyc(32);
    rd(8'h04, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL late_done: got %h want 1", v); end
    rd(8'h05, v);
    checks++; if (v !== 32'd60) begin failures++; $display("FAIL late_resl: got %h want 3c", v); end
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL late_irq_off: got %b want 0", m_interrupt); end
    wr(8'h07, 32'h1);
    checks++; if (m_interrupt !== 1'b1) begin failures++; $display("FAIL late_irq_on: got %b want 1", m_interrupt); end
    wr(8'h07, 32'h0);
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL late_irq_dis: got %b want 0", m_interrupt); end
    wr(8'h07, 32'h1);
    wr(8'h03, 32'h1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(8'h00, 32'd24); wr(8'h01, 32'd5); wr(8'h02, 32'h1);
    cyc(9);
    wr(8'h00, 32'd7);
    cyc(4);
    wr(8'h02, 32'h1);
    cyc(16);
    rd(8'h04, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL b2b_busy31: got %h want 2", v); end
    cyc(1);
    rd(8'h05, v);
    checks++; if (v !== 32'd120) begin failures++; $display("FAIL b2b_res1: got %h want 78", v); end
    rd(8'h00, v);
    checks++; if (v !== 32'd7) begin failures++; $display("FAIL b2b_mcand: got %h want 7", v); end
    wr(8'h02, 32'h1);
    rd(8'h05, v);
    checks++; if (v !== 32'd120) begin failures++; $display("FAIL b2b_held: got %h want 78", v); end
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL b2b_irq_restart: got %b want 0", m_interrupt); end
    cyc(32);
    rd(8'h05, v);
    checks++; if (v !== 32'd35) begin failures++; $display("FAIL b2b_res2: got %h want 23", v); end
    checks++; if (m_interrupt !== 1'b1) begin failures++; $display("FAIL b2b_irq2: got %b want 1", m_interrupt); end
    wr(8'h03, 32'h1);
  endtask

  task automatic test_abort();
    logic [31:0] v;
    wr(8'h00, 32'd6); wr(8'h01, 32'd7); wr(8'h02, 32'h1);
    cyc(19);
    wr(8'h03, 32'h1);
    rd(8'h04, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL clr_status: got %h want 0", v); end
    cyc(15);
    rd(8'h04, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL clr_status_late: got %h want 0", v); end
    rd(8'h05, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL clr_resl: got %h want 0", v); end
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL clr_irq: got %b want 0", m_interrupt); end
    // Complete one op so reset has non-zero state to clear
    wr(8'h00, 32'd6); wr(8'h01, 32'd7); wr(8'h02, 32'h1);
    cyc(32);
    rd(8'h05, v);
    checks++; if (v !== 32'd42) begin failures++; $display("FAIL rst_pre_res: got %h want 2a", v); end
    wr(8'h02, 32'h1);
    cyc(19);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (m_interrupt !== 1'b0) begin failures++; $display("FAIL rst_async_irq: got %b want 0", m_interrupt); end
    rd(8'h05, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_async_resl: got %h want 0", v); end
    rd(8'h04, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_async_status: got %h want 0", v); end
    rd(8'h07, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_async_intren: got %h want 0", v); end
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_latency();
    logic [31:0] v;
    wr(8'h07, 32'h1);
    wr(8'h00, 32'd9); wr(8'h01, 32'd0); wr(8'h02, 32'h1);
    cyc(LatZero - 1);
    rd(8'h04, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL lat0_busy: got %h want 2", v); end
    cyc(1);
    rd(8'h04, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL lat0_done: got %h want 1", v); end
    rd(8'h05, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL lat0_res: got %h want 0", v); end
    wr(8'h01, 32'd5); wr(8'h02, 32'h1);
    cyc(LatFive - 1);
    rd(8'h04, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL lat5_busy: got %h want 2", v); end
    cyc(1);
    rd(8'h04, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL lat5_done: got %h want 1", v); end
    rd(8'h05, v);
    checks++; if (v !== 32'd45) begin failures++; $display("FAIL lat5_res: got %h want 2d", v); end
    checks++; if (m_interrupt !== 1'b1) begin failures++; $display("FAIL lat5_irq: got %b want 1", m_interrupt); end
  endtask

  task automatic test_unmapped();
    logic [31:0] v;
    wr(8'h10, 32'hDEAD_BEEF);
    rd(8'h10, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_rd: got %h want 0", v); end
    rd(8'h05, v);
    checks++; if (v !== 32'd45) begin failures++; $display("FAIL unmapped_nowr: got %h want 2d", v); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_max();
    test_intr_late();
    test_back_to_back();
    test_abort();
    test_latency();
    test_unmapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
